// File: rtl/mv_seq_pkg.sv
// Shared types and default widths for the matrix-vector sequencer and its register block.
package mv_seq_pkg;

  localparam int unsigned DefAddrWidth  = 11;
  localparam int unsigned DefStep       = 6;
  localparam int unsigned DefBeatsWidth = 8;
  localparam int unsigned DefRowsWidth  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mv_sequencer_if.sv
// Datapath-side bundle: memory read beats, MAC row framing and row-result write-back.
interface mv_sequencer_if
  import mv_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned ROWS_WIDTH = DefRowsWidth
);

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  mac_clr;
  logic                  mac_last;
  logic                  res_valid;
  logic                  wr_en;
  logic [ROWS_WIDTH-1:0] wr_row;

  // Sequencer side
  modport master (
    output rd_addr, rd_valid, mac_clr, mac_last, wr_en, wr_row,
    input  rd_ready, res_valid
  );

  // Memory / datapath side
  modport slave (
    input  rd_addr, rd_valid, mac_clr, mac_last, wr_en, wr_row,
    output rd_ready, res_valid
  );

endinterface

// File: rtl/stride_addr_gen.sv
// Strided beat address generator with column/row position tracking and wrap flags.
module stride_addr_gen
  import mv_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned STEP        = DefStep,
  parameter int unsigned BEATS_WIDTH = DefBeatsWidth,
  parameter int unsigned ROWS_WIDTH  = DefRowsWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [ADDR_WIDTH-1:0]  base_i,
  input  logic                   accept_i,
  input  logic [BEATS_WIDTH-1:0] beats_i,
  input  logic [ROWS_WIDTH-1:0]  rows_i,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic                   col_first_o,
  output logic                   col_last_o,
  output logic                   row_last_o
);

  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BEATS_WIDTH-1:0] col_q, col_d;
  logic [ROWS_WIDTH-1:0]  row_q, row_d;

  assign addr_o      = addr_q;
  assign col_first_o = (col_q == '0);
  assign col_last_o  = (col_q == beats_i - BEATS_WIDTH'(1));
  assign row_last_o  = (row_q == rows_i - ROWS_WIDTH'(1));

  // Load on job start; otherwise advance one beat per accept, addresses linear across rows
  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (load_i) begin
      addr_d = base_i;
      col_d  = '0;
      row_d  = '0;
    end else if (accept_i) begin
      addr_d = addr_q + ADDR_WIDTH'(STEP);  // wraps modulo 2^ADDR_WIDTH
      if (col_last_o) begin
        col_d = '0;
        row_d = row_q + ROWS_WIDTH'(1);
      end else begin
        col_d = col_q + BEATS_WIDTH'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/mv_sequencer.sv
// Matrix-vector job sequencer: streams row beats, frames rows for the MAC, counts results.
module mv_sequencer
  import mv_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned STEP        = DefStep,
  parameter int unsigned BEATS_WIDTH = DefBeatsWidth,
  parameter int unsigned ROWS_WIDTH  = DefRowsWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_i,
  input  logic [BEATS_WIDTH-1:0] cfg_beats_i,
  input  logic [ROWS_WIDTH-1:0]  cfg_rows_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  mv_sequencer_if.master         bus
);

  state_e                 state_q, state_d;
  logic [BEATS_WIDTH-1:0] beats_q, beats_d;
  logic [ROWS_WIDTH-1:0]  rows_q, rows_d;
  logic [ROWS_WIDTH-1:0]  res_cnt_q, res_cnt_d;
  logic                   err_q, err_d;

  logic                  start_ok, accept;
  logic                  col_first, col_last, row_last;
  logic [ADDR_WIDTH-1:0] addr;

  stride_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STEP        (STEP),
    .BEATS_WIDTH (BEATS_WIDTH),
    .ROWS_WIDTH  (ROWS_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (start_ok),
    .base_i      (cfg_base_i),
    .accept_i    (accept),
    .beats_i     (beats_q),
    .rows_i      (rows_q),
    .addr_o      (addr),
    .col_first_o (col_first),
    .col_last_o  (col_last),
    .row_last_o  (row_last)
  );

  assign bus.rd_valid = (state_q == StStream);
  assign accept       = bus.rd_valid && bus.rd_ready;
  assign bus.rd_addr  = bus.rd_valid ? addr : '0;
  assign bus.mac_clr  = bus.rd_valid && col_first;
  assign bus.mac_last = bus.rd_valid && col_last;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;
  assign bus.wr_en    = bus.res_valid && busy_o && (res_cnt_q < rows_q);
  assign bus.wr_row   = res_cnt_q;

  // Next-state, job latching and result counting
  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    rows_d    = rows_q;
    res_cnt_d = res_cnt_q;
    err_d     = 1'b0;
    start_ok  = 1'b0;

    if (bus.wr_en) res_cnt_d = res_cnt_q + ROWS_WIDTH'(1);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_beats_i == '0 || cfg_rows_i == '0) begin
            err_d = 1'b1;
          end else begin
            start_ok  = 1'b1;
            beats_d   = cfg_beats_i;
            rows_d    = cfg_rows_i;
            res_cnt_d = '0;
            state_d   = StStream;
          end
        end
      end
      StStream: begin
        if (accept && col_last && row_last) state_d = StDrain;
      end
      StDrain: begin
        // Look at the post-increment count so done follows the last result by one cycle
        if (res_cnt_d == rows_q) state_d = StDone;
      end
      StDone: begin
        res_cnt_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and job registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      beats_q   <= '0;
      rows_q    <= '0;
      res_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      rows_q    <= rows_d;
      res_cnt_q <= res_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mv_sequencer.sv
// Directed self-checking bench for mv_sequencer.
module tb_mv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] cfg_base;
  logic [7:0]  cfg_beats;
  logic [7:0]  cfg_rows;
  logic        busy, done, err;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  mv_sequencer_if #(.ADDR_WIDTH(11), .ROWS_WIDTH(8)) bus ();

  mv_sequencer #(
    .ADDR_WIDTH  (11),
    .STEP        (6),
    .BEATS_WIDTH (8),
    .ROWS_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .cfg_base_i  (cfg_base),
    .cfg_beats_i (cfg_beats),
    .cfg_rows_i  (cfg_rows),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [10:0] base, input logic [7:0] beats,
                           input logic [7:0] rows);
    cfg_base  = base;
    cfg_beats = beats;
    cfg_rows  = rows;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
    check_eq({tag, "_valid"}, 32'(bus.rd_valid), 0);
    check_eq({tag, "_addr"}, 32'(bus.rd_addr), 0);
    check_eq({tag, "_clr"}, 32'(bus.mac_clr), 0);
    check_eq({tag, "_last"}, 32'(bus.mac_last), 0);
    check_eq({tag, "_wren"}, 32'(bus.wr_en), 0);
    check_eq({tag, "_wrrow"}, 32'(bus.wr_row), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_beat;
    int exp_addr;

    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_beats = '0; cfg_rows = '0;
    bus.rd_ready = 1'b0; bus.res_valid = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Basic job: base 0, 2 beats x 3 rows
    bus.rd_ready = 1'b1;
    start_job(11'd0, 8'd2, 8'd3);
    check_eq("basic_busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      check_eq("basic_valid", 32'(bus.rd_valid), 1);
      check_eq("basic_addr", 32'(bus.rd_addr), 32'(i * 6));
      check_eq("basic_clr", 32'(bus.mac_clr), 32'(i % 2 == 0));
      check_eq("basic_last", 32'(bus.mac_last), 32'(i % 2 == 1));
      tick();
    end
    check_eq("basic_drain_valid", 32'(bus.rd_valid), 0);
    check_eq("basic_drain_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1;
      #1;
      check_eq("basic_wren", 32'(bus.wr_en), 1);
      check_eq("basic_wrrow", 32'(bus.wr_row), 32'(i));
      check_eq("basic_nodone", 32'(done), 0);
      tick();
    end
    bus.res_valid = 1'b0;
    check_eq("basic_done", 32'(done), 1);
    check_eq("basic_done_busy", 32'(busy), 1);
    tick();
    check_eq("basic_done_pulse", 32'(done), 0);
    check_eq("basic_idle_busy", 32'(busy), 0);

    // Backpressure 1010..., plus a start during STREAM that must be ignored
    start_job(11'd100, 8'd3, 8'd1);
    exp_beat = 0;
    for (int cyc = 0; cyc < 20 && exp_beat < 3; cyc++) begin
      bus.rd_ready = (cyc % 2 == 0);
      start        = (cyc == 1);
      cfg_rows     = 8'd0;
      #1;
      check_eq("bp_valid", 32'(bus.rd_valid), 1);
      check_eq("bp_addr", 32'(bus.rd_addr), 32'(100 + 6 * exp_beat));
      check_eq("bp_clr", 32'(bus.mac_clr), 32'(exp_beat == 0));
      check_eq("bp_last", 32'(bus.mac_last), 32'(exp_beat == 2));
      check_eq("bp_err", 32'(err), 0);
      if (bus.rd_ready) exp_beat++;
      tick();
    end
    start = 1'b0;
    check_eq("bp_beats", 32'(exp_beat), 3);
    check_eq("bp_drain_valid", 32'(bus.rd_valid), 0);
    check_eq("bp_drain_err", 32'(err), 0);
    bus.res_valid = 1'b1;
    #1;
    check_eq("bp_wren", 32'(bus.wr_en), 1);
    check_eq("bp_wrrow", 32'(bus.wr_row), 0);
    tick();
    bus.res_valid = 1'b0;
    check_eq("bp_done", 32'(done), 1);
    tick();
    check_eq("bp_idle_busy", 32'(busy), 0);

    // Wrap, single-beat rows, results during STREAM, final beat and result together
    bus.rd_ready = 1'b1;
    start_job(11'd2040, 8'd1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      exp_addr = (2040 + 6 * i) % 2048;
      bus.res_valid = 1'b1;
      #1;
      check_eq("wrap_valid", 32'(bus.rd_valid), 1);
      check_eq("wrap_addr", 32'(bus.rd_addr), 32'(exp_addr));
      check_eq("wrap_clr", 32'(bus.mac_clr), 1);
      check_eq("wrap_last", 32'(bus.mac_last), 1);
      check_eq("wrap_wren", 32'(bus.wr_en), 1);
      check_eq("wrap_wrrow", 32'(bus.wr_row), 32'(i));
      tick();
    end
    // Fourth result in DRAIN is surplus
    #1;
    check_eq("extra_valid", 32'(bus.rd_valid), 0);
    check_eq("extra_busy", 32'(busy), 1);
    check_eq("extra_nodone", 32'(done), 0);
    check_eq("extra_wren", 32'(bus.wr_en), 0);
    tick();
    bus.res_valid = 1'b0;
    check_eq("wrap_done", 32'(done), 1);
    tick();
    bus.res_valid = 1'b1;
    #1;
    check_eq("idle_res_wren", 32'(bus.wr_en), 0);
    check_eq("idle_res_busy", 32'(busy), 0);
    tick();
    bus.res_valid = 1'b0;
    check_eq("idle_res_busy2", 32'(busy), 0);

    // Rejections
    start_job(11'd5, 8'd4, 8'd0);
    check_eq("rej_rows_err", 32'(err), 1);
    check_eq("rej_rows_busy", 32'(busy), 0);
    tick();
    check_eq("rej_rows_err_pulse", 32'(err), 0);
    start_job(11'd5, 8'd0, 8'd2);
    check_eq("rej_beats_err", 32'(err), 1);
    check_eq("rej_beats_busy", 32'(busy), 0);
    check_eq("rej_beats_valid", 32'(bus.rd_valid), 0);
    tick();
    check_eq("rej_beats_err_pulse", 32'(err), 0);

    // Reset mid-STREAM at beat 3
    start_job(11'd50, 8'd2, 8'd4);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_pre_addr", 32'(bus.rd_addr), 32'(50 + 6 * i));
      tick();
    end
    check_eq("rst_beat3_addr", 32'(bus.rd_addr), 68);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("rst_mid");
    tick();
    check_quiet("rst_after");

    // Fresh job after reset
    start_job(11'd10, 8'd1, 8'd1);
    check_eq("post_valid", 32'(bus.rd_valid), 1);
    check_eq("post_addr", 32'(bus.rd_addr), 10);
    check_eq("post_clr", 32'(bus.mac_clr), 1);
    check_eq("post_last", 32'(bus.mac_last), 1);
    tick();
    check_eq("post_drain_valid", 32'(bus.rd_valid), 0);
    bus.res_valid = 1'b1;
    #1;
    check_eq("post_wrrow", 32'(bus.wr_row), 0);
    check_eq("post_wren", 32'(bus.wr_en), 1);
    tick();
    bus.res_valid = 1'b0;
    check_eq("post_done", 32'(done), 1);
    tick();
    check_eq("post_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
